// File: rtl/fetch_pkg.sv
// Shared definitions for the dual-wide fetch stage: opcodes, issue codes, FSM states, slot record.
// Optional STATIC_PRED_EN selects static branch prediction in fetch_predecode.
package fetch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ISSUE_NONE = 2'b00;
  localparam logic [1:0] ISSUE_ONE  = 2'b01;
  localparam logic [1:0] ISSUE_TWO  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        isbranch;
    logic        taken;
  } slot_t;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of one fetched word: branch/JAL detect, static prediction, next PC.
// Prediction only when STATIC_PRED_EN is defined; otherwise npc is always pc+4.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_isbranch,
  output logic        o_taken,
  output logic [31:0] o_npc
);

  logic        w_is_b;
  logic        w_is_j;
  logic [31:0] w_imm;

  assign w_is_b     = (i_inst[6:0] == OP_BRANCH);
  assign w_is_j     = (i_inst[6:0] == OP_JAL);
  assign o_isbranch = w_is_b | w_is_j;
  assign w_imm      = w_is_j ? imm_j(i_inst) : imm_b(i_inst);

`ifdef STATIC_PRED_EN
  // Backward B-type (sign bit of the immediate is inst[31]) and every JAL predicted taken.
  assign o_taken = w_is_j | (w_is_b & i_inst[31]);
`else
  assign o_taken = 1'b0;
`endif

  assign o_npc = i_pc + (o_taken ? w_imm : 32'd4);

endmodule

// File: rtl/fetch_pair.sv
// Dual-wide fetch stage: owns the PC, fetches aligned 64-bit pairs, predecodes and forms issue groups.
// STATIC_PRED_EN (in fetch_predecode) enables taken-branch prediction and slot-2 drop.
module fetch_pair
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        stop,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  output logic [1:0]  issue,
  output logic [31:0] out1_inst,
  output logic [31:0] out1_pc,
  output logic [31:0] out1_npc,
  output logic [31:0] out2_inst,
  output logic [31:0] out2_pc,
  output logic [31:0] out2_npc,
  output logic        isbranch1,
  output logic        br_taken1,
  output logic        isbranch2,
  output logic        br_taken2
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc;
  logic [1:0]   r_issue;
  slot_t        r_s1, r_s2;

  logic         w_pending, w_consume, w_req, w_load, w_outstanding;
  logic [31:0]  w_pc_lo, w_pc_hi;
  logic         w_lo_isb, w_lo_tk, w_hi_isb, w_hi_tk;
  logic [31:0]  w_lo_npc, w_hi_npc;
  slot_t        w_lo, w_hi, w_g_s1, w_g_s2;
  logic [1:0]   w_g_issue;
  logic [31:0]  w_g_next_pc;
  logic         w_unused;

  assign w_pending = (r_issue != ISSUE_NONE);
  assign w_consume = w_pending & ~stop;
  assign w_pc_lo   = {r_pc[31:3], 3'b000};
  assign w_pc_hi   = {r_pc[31:3], 3'b100};
  assign w_unused  = ^r_pc[1:0];

  // A stalled group keeps RUN from issuing, so a response never lands on top of it.
  assign w_req     = (r_state == ST_RUN) & ~(w_pending & stop);
  assign imem_req  = w_req & rst_n;
  assign imem_addr = w_pc_lo;

  fetch_predecode u_pd_lo (
    .i_inst     (imem_rdata[31:0]),
    .i_pc       (w_pc_lo),
    .o_isbranch (w_lo_isb),
    .o_taken    (w_lo_tk),
    .o_npc      (w_lo_npc)
  );

  fetch_predecode u_pd_hi (
    .i_inst     (imem_rdata[63:32]),
    .i_pc       (w_pc_hi),
    .o_isbranch (w_hi_isb),
    .o_taken    (w_hi_tk),
    .o_npc      (w_hi_npc)
  );

  assign w_lo = '{inst: imem_rdata[31:0],  pc: w_pc_lo, npc: w_lo_npc,
                  isbranch: w_lo_isb, taken: w_lo_tk};
  assign w_hi = '{inst: imem_rdata[63:32], pc: w_pc_hi, npc: w_hi_npc,
                  isbranch: w_hi_isb, taken: w_hi_tk};

  // Single instructions always travel in slot 2; slot 1 is only used for a full pair.
  always_comb begin
    w_g_s1      = '0;
    w_g_s2      = w_hi;
    w_g_issue   = ISSUE_ONE;
    w_g_next_pc = w_hi.npc;
    if (!r_pc[2]) begin
      if (w_lo.taken) begin
        w_g_s2      = w_lo;
        w_g_next_pc = w_lo.npc;
      end else begin
        w_g_s1    = w_lo;
        w_g_issue = ISSUE_TWO;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_outstanding = ((r_state == ST_WAIT) || (r_state == ST_DROP)) ? ~imem_rvalid : w_req;
    case (r_state)
      ST_RUN:  w_state_nxt = w_req ? ST_WAIT : ST_HOLD;
      ST_WAIT: begin
        if (imem_rvalid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_HOLD: if (!stop) w_state_nxt = ST_RUN;
      ST_DROP: if (imem_rvalid) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
    if (flush) begin
      w_load      = 1'b0;
      w_state_nxt = w_outstanding ? ST_DROP : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next fetch PC advances at load time so the following request overlaps the pending group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_issue <= ISSUE_NONE;
      r_s1    <= '0;
      r_s2    <= '0;
    end else if (flush) begin
      r_pc    <= redirect_pc;
      r_issue <= ISSUE_NONE;
      r_s1    <= '0;
      r_s2    <= '0;
    end else if (w_load) begin
      r_pc    <= w_g_next_pc;
      r_issue <= w_g_issue;
      r_s1    <= w_g_s1;
      r_s2    <= w_g_s2;
    end else if (w_consume) begin
      r_issue <= ISSUE_NONE;
      r_s1    <= '0;
      r_s2    <= '0;
    end
  end

  assign issue     = r_issue;
  assign out1_inst = r_s1.inst;
  assign out1_pc   = r_s1.pc;
  assign out1_npc  = r_s1.npc;
  assign isbranch1 = r_s1.isbranch;
  assign br_taken1 = r_s1.taken;
  assign out2_inst = r_s2.inst;
  assign out2_pc   = r_s2.pc;
  assign out2_npc  = r_s2.npc;
  assign isbranch2 = r_s2.isbranch;
  assign br_taken2 = r_s2.taken;

endmodule
